// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - button/switch inputs and count/display outputs of the countdown core
interface countdown_timer_if;
   logic        pulse_btnu;
   logic        pulse_btnl;
   logic        pulse_btnr;
   logic        pulse_btnd;
   logic        sw0;
   logic        sw1;
   logic [13:0] count;
   logic [3:0]  dig3;
   logic [3:0]  dig2;
   logic [3:0]  dig1;
   logic [3:0]  dig0;
   logic        zero;
   logic        low;

   modport master (
      output pulse_btnu, pulse_btnl, pulse_btnr, pulse_btnd, sw0, sw1,
      input  count, dig3, dig2, dig1, dig0, zero, low
   );

   modport slave (
      input  pulse_btnu, pulse_btnl, pulse_btnr, pulse_btnd, sw0, sw1,
      output count, dig3, dig2, dig1, dig0, zero, low
   );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - saturating 0..9999 second countdown with button adds, presets and BCD digits
module countdown_timer #(
   parameter int TICK_CYCLES = 100000000,
   parameter int ADD_U       = 10,
   parameter int ADD_L       = 180,
   parameter int ADD_R       = 200,
   parameter int ADD_D       = 550,
   parameter int MAX_COUNT   = 9999,
   parameter int LOW_LIMIT   = 200
) (
   input logic              clk,
   input logic              rst,
   countdown_timer_if.slave tmr
);
   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [13:0] count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]  hist_q;
   logic [3:0]  btn;
   logic [3:0]  rise;
   logic [10:0] add_sum;
   logic        tick;
   logic        dec;
   logic [14:0] sum;
   logic [15:0] bcd;

   assign btn  = {tmr.pulse_btnd, tmr.pulse_btnr, tmr.pulse_btnl, tmr.pulse_btnu};
   assign rise = btn & ~hist_q;

   always_comb begin
      add_sum = '0;
      if (rise[0]) add_sum = add_sum + 11'(ADD_U);
      if (rise[1]) add_sum = add_sum + 11'(ADD_L);
      if (rise[2]) add_sum = add_sum + 11'(ADD_R);
      if (rise[3]) add_sum = add_sum + 11'(ADD_D);

      tick = (presc_q == PW'(TICK_CYCLES - 1));
      dec  = tick && (count_q != '0);
      // dec is only taken when count is nonzero, so the subtraction cannot wrap
      sum  = {1'b0, count_q} + {4'b0, add_sum} - {14'b0, dec};

      count_d = (sum > 15'(MAX_COUNT)) ? 14'(MAX_COUNT) : sum[13:0];
      presc_d = ((count_q == '0) || tick) ? '0 : presc_q + 1'b1;

      if (tmr.sw1) begin
         count_d = 14'd185;
         presc_d = '0;
      end else if (tmr.sw0) begin
         count_d = 14'd15;
         presc_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         presc_q <= '0;
         hist_q  <= btn;
      end else begin
         count_q <= count_d;
         presc_q <= presc_d;
         hist_q  <= btn;
      end
   end

   // shift-add-3 binary to BCD; 14 input bits fit in four digits for counts up to 9999
   always_comb begin
      bcd = '0;
      for (int i = 13; i >= 0; i--) begin
         if (bcd[3:0]   > 4'd4) bcd[3:0]   = bcd[3:0]   + 4'd3;
         if (bcd[7:4]   > 4'd4) bcd[7:4]   = bcd[7:4]   + 4'd3;
         if (bcd[11:8]  > 4'd4) bcd[11:8]  = bcd[11:8]  + 4'd3;
         if (bcd[15:12] > 4'd4) bcd[15:12] = bcd[15:12] + 4'd3;
         bcd = {bcd[14:0], count_q[i]};
      end
   end

   assign tmr.count = count_q;
   assign tmr.dig3  = bcd[15:12];
   assign tmr.dig2  = bcd[11:8];
   assign tmr.dig1  = bcd[7:4];
   assign tmr.dig0  = bcd[3:0];
   assign tmr.zero  = (count_q == '0);
   assign tmr.low   = (count_q != '0) && (count_q < 14'(LOW_LIMIT));
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - scoreboard bench for countdown_timer with a short tick period
module tb_countdown_timer;
   localparam int T = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   countdown_timer_if bus ();

   countdown_timer #(.TICK_CYCLES(T)) dut (
      .clk (clk),
      .rst (rst),
      .tmr (bus)
   );

   int total = 0;
   int bad   = 0;
   int sb[$];
   int m_cnt   = 0;
   int m_presc = 0;
   logic [3:0] m_hist = '0;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int bcd_of(input int v);
      return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
             (((v / 10) % 10) << 4) | (v % 10);
   endfunction

   // reference behaviour evaluated with the inputs that will be sampled at the coming edge
   task automatic model_edge();
      logic [3:0] b, e;
      int add, nxt, np;
      bit tk;
      b = {bus.pulse_btnd, bus.pulse_btnr, bus.pulse_btnl, bus.pulse_btnu};
      if (rst) begin
         m_cnt = 0; m_presc = 0; m_hist = b;
      end else begin
         e = b & ~m_hist;
         m_hist = b;
         if (bus.sw1) begin
            m_cnt = 185; m_presc = 0;
         end else if (bus.sw0) begin
            m_cnt = 15; m_presc = 0;
         end else begin
            add = (e[0] ? 10 : 0) + (e[1] ? 180 : 0) + (e[2] ? 200 : 0) + (e[3] ? 550 : 0);
            tk  = (m_presc == T - 1);
            nxt = m_cnt + add - ((tk && m_cnt != 0) ? 1 : 0);
            if (nxt > 9999) nxt = 9999;
            np = (m_cnt == 0 || tk) ? 0 : m_presc + 1;
            m_cnt = nxt; m_presc = np;
         end
      end
   endtask

   task automatic step();
      int e;
      model_edge();
      sb.push_back(m_cnt);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      chk("count", int'(bus.count), e);
      chk("digits", int'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), bcd_of(e));
      chk("zero", int'(bus.zero), (e == 0) ? 1 : 0);
      chk("low", int'(bus.low), (e > 0 && e < 200) ? 1 : 0);
   endtask

   task automatic set_btn(input logic [3:0] m);
      {bus.pulse_btnd, bus.pulse_btnr, bus.pulse_btnl, bus.pulse_btnu} = m;
   endtask

   task automatic pulse(input logic [3:0] m);
      set_btn(m);
      step();
      set_btn(4'b0);
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic load(input int target);
      int guard;
      do_reset();
      guard = 0;
      while (m_cnt < target && guard < 100) begin
         if (target - m_cnt >= 550) pulse(4'b1000);
         else if (target - m_cnt >= 200) pulse(4'b0100);
         else if (target - m_cnt >= 180) pulse(4'b0010);
         else pulse(4'b0001);
         guard++;
      end
      guard = 0;
      while (m_cnt != target && guard < 300) begin
         step();
         guard++;
      end
      chk("load", int'(bus.count), target);
   endtask

   task automatic wait_change(input int from);
      int guard;
      guard = 0;
      while (int'(bus.count) == from && guard < 4 * T) begin
         step();
         guard++;
      end
   endtask

   initial begin
      int guard;
      set_btn(4'b0);
      bus.sw0 = 1'b0;
      bus.sw1 = 1'b0;

      // button held through reset must never add
      rst = 1'b1;
      set_btn(4'b0001);
      step();
      step();
      chk("rst_count", int'(bus.count), 0);
      chk("rst_zero", int'(bus.zero), 1);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("held_count", int'(bus.count), 0);
      chk("held_digits", int'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 0);
      chk("held_zero", int'(bus.zero), 1);
      set_btn(4'b0);
      step();

      set_btn(4'b1000);
      step();
      chk("d_count", int'(bus.count), 550);
      chk("d_digits", int'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 16'h0550);
      chk("d_low", int'(bus.low), 0);
      set_btn(4'b0);
      for (int i = 0; i < 9; i++) step();
      chk("pre_tick", int'(bus.count), 550);
      step();
      chk("tick1", int'(bus.count), 549);
      for (int i = 0; i < 20; i++) step();
      chk("tick3", int'(bus.count), 547);

      for (int i = 0; i < 10; i++) pulse(4'b1111);
      set_btn(4'b1111);
      step();
      chk("sat_count", int'(bus.count), 9999);
      chk("sat_digits", int'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 16'h9999);
      set_btn(4'b0);
      step();
      set_btn(4'b0001);
      step();
      chk("sat_hold", int'(bus.count), 9999);
      set_btn(4'b0);
      step();

      bus.sw0 = 1'b1;
      bus.sw1 = 1'b1;
      step();
      chk("sw_count", int'(bus.count), 185);
      chk("sw_low", int'(bus.low), 1);
      for (int i = 0; i < 8; i++) pulse(4'($urandom_range(1, 15)));
      for (int i = 0; i < 10; i++) step();
      chk("sw_held", int'(bus.count), 185);
      bus.sw0 = 1'b0;
      bus.sw1 = 1'b0;
      for (int i = 0; i < 9; i++) step();
      chk("rel_pre", int'(bus.count), 185);
      step();
      chk("rel_tick", int'(bus.count), 184);

      bus.sw0 = 1'b1;
      step();
      chk("sw0_count", int'(bus.count), 15);
      bus.sw0 = 1'b0;
      step();

      load(1);
      guard = 0;
      while (m_presc != T - 1 && guard < 2 * T) begin
         step();
         guard++;
      end
      set_btn(4'b0001);
      step();
      chk("add_on_tick", int'(bus.count), 10);
      set_btn(4'b0);
      step();

      load(1);
      wait_change(1);
      chk("to_zero", int'(bus.count), 0);
      chk("to_zero_flag", int'(bus.zero), 1);
      for (int i = 0; i < 50; i++) step();
      chk("zero_stays", int'(bus.count), 0);

      load(1000);
      wait_change(1000);
      chk("borrow_count", int'(bus.count), 999);
      chk("borrow_digits", int'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 16'h0999);

      load(200);
      chk("at200_low", int'(bus.low), 0);
      wait_change(200);
      chk("b199_count", int'(bus.count), 199);
      chk("b199_low", int'(bus.low), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
